// File: rtl/loader_pkg.sv
// ============================================================================
//  Module      : loader_pkg
//  Description : Shared types and constants for the program loader slice.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package loader_pkg;

    localparam int BYTES_PER_WORD = 4;

    localparam logic [6:0] OP_IMM = 7'b0010011;
    localparam logic [6:0] OP     = 7'b0110011;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RECV  = 3'd1,
        ST_WRITE = 3'd2,
        ST_CHECK = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    // True when the byte about to be accepted completes a word.
    function automatic logic is_last_byte(input logic [1:0] idx);
        return idx == 2'(BYTES_PER_WORD - 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/program_loader_if.sv
// ============================================================================
//  Module      : program_loader_if
//  Description : Byte-stream input and program-memory write port bundle.
//                master = the loader, slave = byte source plus memory.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface program_loader_if #(
    parameter int ADDR_WIDTH = 5
);
    logic                  byte_valid;
    logic [7:0]            byte_data;
    logic                  byte_ready;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [31:0]           mem_wdata;

    modport master (
        input  byte_valid,
        input  byte_data,
        output byte_ready,
        output mem_we,
        output mem_addr,
        output mem_wdata
    );

    modport slave (
        output byte_valid,
        output byte_data,
        input  byte_ready,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata
    );
endinterface

`default_nettype wire

// File: rtl/byte_assembler.sv
// ============================================================================
//  Module      : byte_assembler
//  Description : Packs a byte stream little-endian into a 32-bit word and
//                tracks the byte index within the word.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module byte_assembler
    import loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr_i,
    input  logic        shift_en_i,
    input  logic [7:0]  byte_i,
    output logic [31:0] word_o,
    output logic [1:0]  idx_o
);

    logic [31:0] word_q, word_d;
    logic [1:0]  idx_q,  idx_d;

    always_comb begin
        word_d = word_q;
        idx_d  = idx_q;
        if (clr_i) begin
            idx_d = 2'd0;
        end else if (shift_en_i) begin
            word_d[{idx_q, 3'b000} +: 8] = byte_i;
            idx_d                        = idx_q + 2'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_q <= '0;
            idx_q  <= '0;
        end else begin
            word_q <= word_d;
            idx_q  <= idx_d;
        end
    end

    assign word_o = word_q;
    assign idx_o  = idx_q;

endmodule

`default_nettype wire

// File: rtl/program_loader.sv
// ============================================================================
//  Module      : program_loader
//  Description : Loads len 32-bit words from a byte stream into program memory
//                and holds the core in reset until the load completes.
//                Optional trailer checksum: PROGRAM_LOADER_CHECKSUM_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module program_loader
    import loader_pkg::*;
#(
    parameter int ADDR_WIDTH = 5,
    parameter int WORD_WIDTH = 32
)(
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [ADDR_WIDTH:0] len,
    program_loader_if.master    bus,
    output logic                core_reset,
    output logic                busy,
    output logic                done,
    output logic                error
);

    localparam logic [ADDR_WIDTH:0] c_max_len = (ADDR_WIDTH+1)'(1) << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] c_one_len = (ADDR_WIDTH+1)'(1);

    state_t                state_q, state_d;
    logic [ADDR_WIDTH:0]   len_q,   len_d;
    logic [ADDR_WIDTH-1:0] cnt_q,   cnt_d;
    logic [ADDR_WIDTH-1:0] addr_q,  addr_d;
    logic                  done_q,  done_d;
    logic                  error_q, error_d;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    logic [7:0]            csum_q,  csum_d;
`endif

    logic                  w_asm_clr;
    logic                  w_asm_shift;
    logic [WORD_WIDTH-1:0] w_word;
    logic [1:0]            w_idx;
    logic                  w_start_acc;
    logic                  w_last_word;

    byte_assembler u_asm (
        .clk        (clk),
        .rst_n      (reset),
        .clr_i      (w_asm_clr),
        .shift_en_i (w_asm_shift),
        .byte_i     (bus.byte_data),
        .word_o     (w_word),
        .idx_o      (w_idx)
    );

    // Only an idle or finished loader reacts to start; mid-load starts are dropped.
    assign w_start_acc = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
    assign w_last_word = ({1'b0, cnt_q} == (len_q - c_one_len));

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        done_d      = done_q;
        error_d     = error_q;
        w_asm_clr   = 1'b0;
        w_asm_shift = 1'b0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        csum_d      = csum_q;
`endif

        case (state_q)
            ST_RECV: begin
                if (bus.byte_valid) begin
                    w_asm_shift = 1'b1;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                    csum_d      = csum_q ^ bus.byte_data;
`endif
                    if (is_last_byte(w_idx)) begin
                        state_d = ST_WRITE;
                    end
                end
            end
            ST_WRITE: begin
                if (w_last_word) begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                    state_d = ST_CHECK;
`else
                    state_d = ST_DONE;
                    done_d  = 1'b1;
`endif
                end else begin
                    addr_d  = addr_q + ADDR_WIDTH'(1);
                    cnt_d   = cnt_q + ADDR_WIDTH'(1);
                    state_d = ST_RECV;
                end
            end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            ST_CHECK: begin
                if (bus.byte_valid) begin
                    if (bus.byte_data == csum_q) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                        error_d = 1'b1;
                    end
                end
            end
`endif
            default: ;
        endcase

        if (w_start_acc) begin
            done_d  = 1'b0;
            error_d = 1'b0;
            if (len == '0) begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                // An empty program still carries a trailer, which must be 0x00.
                state_d = ST_CHECK;
                csum_d  = 8'h00;
`else
                state_d = ST_DONE;
                done_d  = 1'b1;
`endif
            end else if (len > c_max_len) begin
                state_d = ST_IDLE;
                error_d = 1'b1;
            end else begin
                state_d   = ST_RECV;
                len_d     = len;
                cnt_d     = '0;
                addr_d    = '0;
                w_asm_clr = 1'b1;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                csum_d    = 8'h00;
`endif
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            len_q   <= '0;
            cnt_q   <= '0;
            addr_q  <= '0;
            done_q  <= 1'b0;
            error_q <= 1'b0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            csum_q  <= 8'h00;
`endif
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            done_q  <= done_d;
            error_q <= error_d;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            csum_q  <= csum_d;
`endif
        end
    end

    assign bus.byte_ready = (state_q == ST_RECV) || (state_q == ST_CHECK);
    assign bus.mem_we     = (state_q == ST_WRITE);
    assign bus.mem_addr   = addr_q;
    assign bus.mem_wdata  = w_word;

    assign core_reset = (state_q != ST_DONE);
    assign busy       = (state_q == ST_RECV) || (state_q == ST_WRITE) || (state_q == ST_CHECK);
    assign done       = done_q;
    assign error      = error_q;

endmodule

`default_nettype wire

// File: tb/tb_program_loader.sv
// ============================================================================
//  Module      : tb_program_loader
//  Description : Randomised self-checking bench for program_loader with a
//                word-level reference model and a tiny addi-only core model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_program_loader;
    import loader_pkg::*;

    localparam int AW    = 5;
    localparam int DEPTH = 1 << AW;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [AW:0]   len   = '0;
    logic          core_reset, busy, done, error;

    program_loader_if #(.ADDR_WIDTH(AW)) bus ();

    program_loader #(.ADDR_WIDTH(AW), .WORD_WIDTH(32)) dut (
        .clk        (clk),
        .reset      (rst_n),
        .start      (start),
        .len        (len),
        .bus        (bus),
        .core_reset (core_reset),
        .busy       (busy),
        .done       (done),
        .error      (error)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_bad = 0;
    int unsigned cycle = 0;

    always @(posedge clk) cycle <= cycle + 1;

    typedef struct {
        int unsigned addr;
        logic [31:0] data;
        int unsigned cyc;
    } wr_t;

    wr_t         wr_q[$];
    logic [31:0] imem [DEPTH];

    always @(negedge clk) begin
        if (bus.mem_we === 1'b1) begin
            wr_q.push_back('{int'(bus.mem_addr), bus.mem_wdata, cycle});
            imem[bus.mem_addr] <= bus.mem_wdata;
        end
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check_eq({tag, "_byte_ready"}, 64'(bus.byte_ready), 64'd0);
        check_eq({tag, "_mem_we"},     64'(bus.mem_we),     64'd0);
        check_eq({tag, "_mem_addr"},   64'(bus.mem_addr),   64'd0);
        check_eq({tag, "_mem_wdata"},  64'(bus.mem_wdata),  64'd0);
        check_eq({tag, "_core_reset"}, 64'(core_reset),     64'd1);
        check_eq({tag, "_busy"},       64'(busy),           64'd0);
        check_eq({tag, "_done"},       64'(done),           64'd0);
        check_eq({tag, "_error"},      64'(error),          64'd0);
    endtask

    // Called on a negedge; presents bytes and advances only on a handshake.
    // mode: 0 always valid, 1 toggling valid, 2 random valid.
    task automatic send_bytes(input logic [7:0] b[$], input int mode, input int inject_at);
        int i     = 0;
        int guard = 0;
        int inj   = inject_at;
        bit tog   = 1'b1;
        bit v;
        while (i < b.size() && guard < 4000) begin
            start = 1'b0;
            case (mode)
                0:       v = 1'b1;
                1:       begin v = tog; tog = ~tog; end
                default: v = 1'($urandom_range(0, 1));
            endcase
            bus.byte_valid = v;
            bus.byte_data  = v ? b[i] : 8'($urandom);
            if (v && bus.byte_ready) i++;
            if (inj >= 0 && i == inj) begin
                start = 1'b1;
                len   = '0;
                inj   = -1;
            end
            @(negedge clk);
            guard++;
        end
        start          = 1'b0;
        bus.byte_valid = 1'b0;
        check_eq("stream_bytes_taken", 64'(i), 64'(b.size()));
    endtask

    task automatic wait_end();
        int g = 0;
        while (!(done || error) && g < 50) begin
            @(negedge clk);
            g++;
        end
        check_eq("end_reached", 64'(done | error), 64'd1);
    endtask

    // One load of n words, checked against words packed from the payload.
    task automatic run_load(input int n, input logic [7:0] pay[$], input int mode,
                            input int inject_at, input bit bad_trailer);
        logic [7:0]  s[$];
        logic [7:0]  x;
        logic [31:0] w;
        bit          ok;
        s  = pay;
        x  = 8'h00;
        ok = 1'b1;
        foreach (pay[k]) x = x ^ pay[k];
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        s.push_back(bad_trailer ? (x ^ 8'h01) : x);
        ok = !bad_trailer;
`endif
        wr_q.delete();
        start = 1'b1;
        len   = (AW+1)'(n);
        @(negedge clk);
        start = 1'b0;
        check_eq("start_core_reset", 64'(core_reset), 64'd1);
        check_eq("start_done_clr",   64'(done),       64'd0);
        check_eq("start_busy",       64'(busy),       64'd1);
        send_bytes(s, mode, inject_at);
        wait_end();
        check_eq("n_writes", 64'(wr_q.size()), 64'(n));
        for (int k = 0; k < n && k < wr_q.size(); k++) begin
            w = 32'(pay[4*k]) + (32'(pay[4*k+1]) << 8) + (32'(pay[4*k+2]) << 16)
              + (32'(pay[4*k+3]) << 24);
            check_eq($sformatf("wr%0d_addr", k), 64'(wr_q[k].addr), 64'(k));
            check_eq($sformatf("wr%0d_data", k), 64'(wr_q[k].data), 64'(w));
            if (mode == 0 && k > 0)
                check_eq($sformatf("wr%0d_gap", k), 64'(wr_q[k].cyc - wr_q[k-1].cyc), 64'd5);
        end
        check_eq("end_done",       64'(done),       64'(ok));
        check_eq("end_error",      64'(error),      64'(!ok));
        check_eq("end_core_reset", 64'(core_reset), 64'(!ok));
        check_eq("end_busy",       64'(busy),       64'd0);
    endtask

    initial begin
        logic [7:0] p[$];
        logic [7:0] p4[$];
        logic [7:0] p8[$];
        logic [31:0] ins;
        int          xr[32];
        int          n;

        bus.byte_valid = 1'b0;
        bus.byte_data  = 8'h00;
        p4 = '{8'h93, 8'h02, 8'h80, 8'h07};
        p8 = '{8'h93, 8'h02, 8'h80, 8'h07, 8'h93, 8'h02, 8'h80, 8'h0C};

        repeat (2) @(negedge clk);
        check_reset_vals("por");
        rst_n = 1'b1;
        @(negedge clk);

        // Reset in the middle of a word, then a clean reload.
        start = 1'b1;
        len   = (AW+1)'(1);
        @(negedge clk);
        start = 1'b0;
        p = '{8'h93, 8'h02};
        send_bytes(p, 0, -1);
        rst_n = 1'b0;
        @(negedge clk);
        check_reset_vals("mid_reset");
        rst_n = 1'b1;
        @(negedge clk);
        run_load(1, p4, 0, -1, 1'b0);

        // Two-word program, then run it on the addi-only core model.
        run_load(2, p8, 0, -1, 1'b0);
        foreach (xr[i]) xr[i] = 0;
        for (int pc = 0; pc < 2; pc++) begin
            ins = imem[pc];
            if (ins[6:0] == OP_IMM && ins[14:12] == 3'b000 && ins[11:7] != 5'd0)
                xr[ins[11:7]] = xr[ins[19:15]] + int'($signed(ins[31:20]));
        end
        check_eq("core_x5", 64'(xr[5]), 64'd200);

        run_load(1, p4, 1, -1, 1'b0);

        // Empty load.
        wr_q.delete();
        start = 1'b1;
        len   = '0;
        @(negedge clk);
        start = 1'b0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        p = '{8'h00};
        send_bytes(p, 0, -1);
        wait_end();
`endif
        check_eq("len0_done",       64'(done),           64'd1);
        check_eq("len0_core_reset", 64'(core_reset),     64'd0);
        check_eq("len0_no_writes",  64'(wr_q.size()),    64'd0);

        // Oversized load.
        start = 1'b1;
        len   = (AW+1)'(DEPTH + 1);
        @(negedge clk);
        start = 1'b0;
        check_eq("len33_error",      64'(error),      64'd1);
        check_eq("len33_busy",       64'(busy),       64'd0);
        check_eq("len33_core_reset", 64'(core_reset), 64'd1);
        check_eq("len33_done",       64'(done),       64'd0);
        check_eq("len33_no_writes",  64'(wr_q.size()), 64'd0);

        // Start during the second word is ignored; then restart from DONE.
        run_load(2, p8, 0, 5, 1'b0);
        run_load(1, p4, 2, -1, 1'b0);

`ifdef PROGRAM_LOADER_CHECKSUM_EN
        run_load(1, p4, 0, -1, 1'b0);
        run_load(1, p4, 0, -1, 1'b1);
`endif

        // Random programs, one at full depth to reach the top address.
        for (int r = 0; r < 6; r++) begin
            n = (r == 0) ? DEPTH : int'($urandom_range(1, DEPTH));
            p.delete();
            for (int k = 0; k < 4 * n; k++) p.push_back(8'($urandom));
            run_load(n, p, int'($urandom_range(0, 2)), -1, 1'($urandom_range(0, 1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
